// File: rtl/dot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dot_pkg
//  Description : Shared types and helpers for the serial dot-product engine.
//                - state_t      : engine control states (IDLE, RUN, DONE)
//                - acc_width()  : accumulator width that cannot overflow for
//                                 n elements of w bits in either sign mode
//  Revision    : 1.0 - initial release
// ============================================================================
package dot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 2*w bits hold one full product; log2(n) extra bits absorb the growth
    // of summing n of them. At least one guard bit is always kept so that
    // signed (-2^(w-1))^2 stays positive.
    function automatic int acc_width(input int n, input int w);
        int c_guard;
        c_guard = (n <= 1) ? 1 : $clog2(n);
        if (c_guard < 1) begin
            c_guard = 1;
        end
        return 2 * w + c_guard;
    endfunction

endpackage : dot_pkg
`default_nettype wire

// File: rtl/dot_mac.sv
`default_nettype none
// ============================================================================
//  Module      : dot_mac
//  Description : Combinational multiply-accumulate step. Extends both W-bit
//                operands to ACC_W (sign- or zero-extension by i_is_signed),
//                multiplies them and adds the product to the accumulator.
//  Ports       : i_a, i_b      W-bit element operands
//                i_is_signed   1 = two's-complement operands
//                i_acc         current accumulator value
//                o_acc         accumulator plus product
//  Revision    : 1.0 - initial release
// ============================================================================
module dot_mac #(
    parameter int W     = 4,
    parameter int ACC_W = 11
) (
    input  logic [W-1:0]     i_a,
    input  logic [W-1:0]     i_b,
    input  logic             i_is_signed,
    input  logic [ACC_W-1:0] i_acc,
    output logic [ACC_W-1:0] o_acc
);

    logic             w_a_fill;
    logic             w_b_fill;
    logic [ACC_W-1:0] w_a_ext;
    logic [ACC_W-1:0] w_b_ext;
    logic [ACC_W-1:0] w_prod;

    assign w_a_fill = i_is_signed & i_a[W-1];
    assign w_b_fill = i_is_signed & i_b[W-1];
    assign w_a_ext  = {{(ACC_W-W){w_a_fill}}, i_a};
    assign w_b_ext  = {{(ACC_W-W){w_b_fill}}, i_b};

    // Low ACC_W bits of the product of two extended operands equal the true
    // signed/unsigned product modulo 2^ACC_W, which is exact since ACC_W
    // never overflows.
    assign w_prod   = w_a_ext * w_b_ext;
    assign o_acc    = i_acc + w_prod;

endmodule : dot_mac
`default_nettype wire

// File: rtl/dot_serial_mac.sv
`default_nettype none
// ============================================================================
//  Module      : dot_serial_mac
//  Description : Sequential dot-product engine. Loads two N-element vectors
//                in one valid/ready transaction, accumulates a[i]*b[i] one
//                element per clock, then presents the sum until accepted.
//  Ports       : clk, reset          clock / async active-high reset
//                in_valid, in_ready  operand handshake
//                in_a, in_b          packed vectors, element i at [i*W +: W]
//                in_len              element count (values > N clamp to N)
//                in_signed           1 = two's-complement elements
//                out_valid,out_ready result handshake
//                out_sum             dot product, held until next result
//  Revision    : 1.0 - initial release
// ============================================================================
module dot_serial_mac
    import dot_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int W     = 4,
    localparam int LEN_W = $clog2(N + 1),
    localparam int ACC_W = acc_width(N, W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   in_a,
    input  logic [N*W-1:0]   in_b,
    input  logic [LEN_W-1:0] in_len,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum
);

    localparam logic [LEN_W-1:0] C_LEN_MAX = LEN_W'(N);
    localparam logic [LEN_W-1:0] C_LEN_ONE = LEN_W'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [N*W-1:0]     r_a;
    logic [N*W-1:0]     r_b;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_next;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_len_clamp;
    logic               r_signed;
    logic [ACC_W-1:0]   r_sum;
    logic               w_accept;
    logic               w_last;

    assign w_len_clamp = (in_len > C_LEN_MAX) ? C_LEN_MAX : in_len;
    assign w_accept    = in_valid && (r_state == IDLE);
    assign w_last      = (r_state == RUN) && (r_cnt == C_LEN_ONE);
    assign out_sum     = r_sum;

    // Element 0 always sits in the low W bits; the vectors shift down as
    // they are consumed.
    dot_mac #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_mac (
        .i_a         (r_a[W-1:0]),
        .i_b         (r_b[W-1:0]),
        .i_is_signed (r_signed),
        .i_acc       (r_acc),
        .o_acc       (w_acc_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = (w_len_clamp == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_cnt == C_LEN_ONE) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Return to IDLE only; in_ready rises the following cycle.
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_signed <= 1'b0;
            r_sum    <= '0;
        end else if (w_accept) begin
            r_a      <= in_a;
            r_b      <= in_b;
            r_acc    <= '0;
            r_cnt    <= w_len_clamp;
            r_signed <= in_signed;
            // A zero-length job completes on the accept edge itself.
            if (w_len_clamp == '0) begin
                r_sum <= '0;
            end
        end else if (r_state == RUN) begin
            r_acc <= w_acc_next;
            r_a   <= r_a >> W;
            r_b   <= r_b >> W;
            r_cnt <= r_cnt - C_LEN_ONE;
            if (w_last) begin
                r_sum <= w_acc_next;
            end
        end
    end

endmodule : dot_serial_mac
`default_nettype wire

// File: tb/tb_dot_serial_mac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dot_serial_mac
//  Description : Self-checking bench for dot_serial_mac (N=8, W=4, ACC_W=11).
//                Directed vector table, hand-written handshake/reset
//                sequences and random jobs checked against a plain
//                arithmetic dot-product model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_serial_mac;

    localparam int N     = 8;
    localparam int W     = 4;
    localparam int LEN_W = 4;
    localparam int ACC_W = 11;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   in_a;
    logic [N*W-1:0]   in_b;
    logic [LEN_W-1:0] in_len;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;

    int errors = 0;
    int checks = 0;

    dot_serial_mac #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_len    (in_len),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  len;
        bit          sgn;
        logic [10:0] exp_sum;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: direct sum of element products, interpreting nibbles per mode.
    function automatic int model(input logic [31:0] a, input logic [31:0] b,
                                 input int len, input bit sgn);
        int n;
        int sum;
        int ea;
        int eb;
        n   = (len > N) ? N : len;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            ea = int'((a >> (i * W)) & 32'hF);
            eb = int'((b >> (i * W)) & 32'hF);
            if (sgn && ea >= 8) ea = ea - 16;
            if (sgn && eb >= 8) eb = eb - 16;
            sum = sum + ea * eb;
        end
        return sum;
    endfunction

    task automatic start_job(input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] len, input bit sgn, input string name);
        @(negedge clk);
        check({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_len    = len;
        in_signed = sgn;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    // Waits for the result, checks latency/sum/hold, then handshakes it away.
    task automatic finish_job(input logic [10:0] exp_sum, input int exp_lat,
                              input int hold, input string name);
        int lat;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " sum"}, 32'(out_sum), 32'(exp_sum));
        check({name, " in_ready low in DONE"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({name, " held valid"}, 32'(out_valid), 32'd1);
            check({name, " held sum"}, 32'(out_sum), 32'(exp_sum));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({name, " in_ready back"}, 32'(in_ready), 32'd1);
        check({name, " sum kept in IDLE"}, 32'(out_sum), 32'(exp_sum));
    endtask

    task automatic run_txn(input vec_t v, input int hold, input string name);
        int lat;
        lat = (v.len > 4'd8) ? 8 : int'(v.len);
        start_job(v.a, v.b, v.len, v.sgn, name);
        finish_job(v.exp_sum, lat, hold, name);
    endtask

    initial begin
        vec_t        v;
        int          m;
        logic [31:0] mm;

        // element i lives at bits [4i+3:4i]
        tbl[0] = '{32'h87654321, 32'h11111111, 4'd8,  1'b0, 11'd36};
        tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3,  1'b0, 11'd675};
        tbl[2] = '{32'h3A5C9E78, 32'h77777FF8, 4'd2,  1'b1, 11'd57};
        tbl[3] = '{32'h88888888, 32'h88888888, 4'd8,  1'b1, 11'd512};
        tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd0,  1'b0, 11'd0};
        tbl[5] = '{32'h11111111, 32'h11111111, 4'd12, 1'b0, 11'd8};
        tbl[6] = '{32'h77777777, 32'h88888888, 4'd8,  1'b1, 11'd1600}; // -448

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_len    = '0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_sum", 32'(out_sum), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i], i % 3, $sformatf("vec%0d", i));
        end

        // Backpressure with ignored operand pulses during RUN and DONE.
        start_job(32'h87654321, 32'h11111111, 4'd8, 1'b0, "bp");
        in_valid  = 1'b1;
        in_a      = 32'hFFFFFFFF;
        in_b      = 32'hFFFFFFFF;
        in_len    = 4'd8;
        in_signed = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp in_ready in RUN", 32'(in_ready), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("bp valid at 8", 32'(out_valid), 32'd1);
        check("bp sum", 32'(out_sum), 32'd36);
        for (int h = 0; h < 5; h++) begin
            @(posedge clk);
            #1;
            check("bp hold valid", 32'(out_valid), 32'd1);
            check("bp hold sum", 32'(out_sum), 32'd36);
            check("bp hold in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp in_ready after handshake", 32'(in_ready), 32'd1);
        check("bp out_valid after handshake", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("bp stays idle", 32'(in_ready), 32'd1);
        check("bp no stray result", 32'(out_valid), 32'd0);
        check("bp sum kept", 32'(out_sum), 32'd36);

        // Reset three cycles into RUN aborts the job.
        start_job(32'h87654321, 32'h11111111, 4'd8, 1'b0, "rst");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_sum", 32'(out_sum), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_txn(tbl[0], 0, "rerun");

        // Random jobs against the arithmetic model.
        for (int k = 0; k < 40; k++) begin
            v.a     = $urandom;
            v.b     = $urandom;
            v.len   = 4'($urandom_range(0, 15));
            v.sgn   = 1'($urandom_range(0, 1));
            m       = model(v.a, v.b, int'(v.len), v.sgn);
            mm      = 32'(m);
            v.exp_sum = mm[10:0];
            run_txn(v, int'($urandom_range(0, 2)), $sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dot_serial_mac
`default_nettype wire
